// File: rtl/window_motor_ctrl_pkg.sv
// Shared window-motor definitions: state encodings and drive-direction constants.
package window_motor_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN_CW  = 3'd1,
      ST_RUN_CCW = 3'd2,
      ST_BRAKE   = 3'd3,
      ST_FAULT   = 3'd4
   } state_t;

   localparam logic DIR_CW  = 1'b0;
   localparam logic DIR_CCW = 1'b1;

   function automatic logic st_busy(state_t s);
      return (s != ST_IDLE) && (s != ST_FAULT);
   endfunction

endpackage

// File: rtl/window_motor_ctrl_if.sv
// Request / end-stop / drive bundle between the window FSM side and the motor controller.
interface window_motor_ctrl_if;
   logic open_cw;
   logic close_ccw;
   logic limit_open;
   logic limit_closed;
   logic motor_cw;
   logic motor_ccw;
   logic busy;
   logic fault;

   modport master (
      output open_cw, close_ccw, limit_open, limit_closed,
      input  motor_cw, motor_ccw, busy, fault
   );

   modport slave (
      input  open_cw, close_ccw, limit_open, limit_closed,
      output motor_cw, motor_ccw, busy, fault
   );
endinterface

// File: rtl/window_motor_ctrl_sync_2ff.sv
// Two-flop synchronizer for an asynchronous 1-bit input, synchronously cleared to 0.
module sync_2ff (
   input  logic clk,
   input  logic n_reset,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/window_motor_ctrl.sv
// Window motor drive: turns one-cycle open/close requests into sustained H-bridge drive with
// end-stop stop, run timeout and dead time. Define WINDOW_MOTOR_REVERSE_EN for direct reversal.
module window_motor_ctrl
   import window_motor_ctrl_pkg::*;
#(
   parameter int RUN_TIMEOUT = 50_000_000,
   parameter int DEAD_TIME   = 1_000_000,
   parameter int CNT_W       = 26
) (
   input  logic                clk,
   input  logic                n_reset,
   window_motor_ctrl_if.slave  bus
);
   localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_TIME - 1);

   logic             lo_s, lc_s;
   state_t           state, state_nxt;
   logic [CNT_W-1:0] timer, timer_nxt, timer_inc;
   logic             motor_cw_q, motor_ccw_q, busy_q, fault_q;
`ifdef WINDOW_MOTOR_REVERSE_EN
   logic             pend_vld, pend_vld_nxt, pend_dir, pend_dir_nxt;
`endif

   sync_2ff u_sync_lo (.clk(clk), .n_reset(n_reset), .d(bus.limit_open),   .q(lo_s));
   sync_2ff u_sync_lc (.clk(clk), .n_reset(n_reset), .d(bus.limit_closed), .q(lc_s));

   assign timer_inc = (timer == '1) ? timer : timer + CNT_W'(1);

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
`ifdef WINDOW_MOTOR_REVERSE_EN
      pend_vld_nxt = pend_vld;
      pend_dir_nxt = pend_dir;
`endif
      case (state)
         ST_IDLE: begin
            if (lo_s && lc_s) state_nxt = ST_FAULT;
            else if (bus.open_cw && !bus.close_ccw && !lo_s) begin
               state_nxt = ST_RUN_CW;
               timer_nxt = '0;
            end else if (bus.close_ccw && !bus.open_cw && !lc_s) begin
               state_nxt = ST_RUN_CCW;
               timer_nxt = '0;
            end
         end
         ST_RUN_CW, ST_RUN_CCW: begin
            // own limit outranks the timeout so a run ending exactly on time is a clean stop
            if (lo_s && lc_s) state_nxt = ST_FAULT;
            else if ((state == ST_RUN_CW) ? lo_s : lc_s) begin
               state_nxt = ST_BRAKE;
               timer_nxt = '0;
            end else if (timer == RUN_LAST) state_nxt = ST_FAULT;
            else if ((state == ST_RUN_CW) ? bus.close_ccw : bus.open_cw) begin
               state_nxt = ST_BRAKE;
               timer_nxt = '0;
`ifdef WINDOW_MOTOR_REVERSE_EN
               pend_vld_nxt = 1'b1;
               pend_dir_nxt = (state == ST_RUN_CW) ? DIR_CCW : DIR_CW;
`endif
            end else timer_nxt = timer_inc;
         end
         ST_BRAKE: begin
            if (lo_s && lc_s) state_nxt = ST_FAULT;
            else if (timer == DEAD_LAST) begin
               state_nxt = ST_IDLE;
`ifdef WINDOW_MOTOR_REVERSE_EN
               pend_vld_nxt = 1'b0;
               if (pend_vld && pend_dir == DIR_CW && !lo_s) begin
                  state_nxt = ST_RUN_CW;
                  timer_nxt = '0;
               end else if (pend_vld && pend_dir == DIR_CCW && !lc_s) begin
                  state_nxt = ST_RUN_CCW;
                  timer_nxt = '0;
               end
`endif
            end else timer_nxt = timer_inc;
         end
         ST_FAULT: state_nxt = ST_FAULT;
         default:  state_nxt = ST_FAULT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state       <= ST_IDLE;
         timer       <= '0;
         motor_cw_q  <= 1'b0;
         motor_ccw_q <= 1'b0;
         busy_q      <= 1'b0;
         fault_q     <= 1'b0;
`ifdef WINDOW_MOTOR_REVERSE_EN
         pend_vld    <= 1'b0;
         pend_dir    <= DIR_CW;
`endif
      end else begin
         state       <= state_nxt;
         timer       <= timer_nxt;
         motor_cw_q  <= (state_nxt == ST_RUN_CW);
         motor_ccw_q <= (state_nxt == ST_RUN_CCW);
         busy_q      <= st_busy(state_nxt);
         fault_q     <= (state_nxt == ST_FAULT);
`ifdef WINDOW_MOTOR_REVERSE_EN
         pend_vld    <= pend_vld_nxt;
         pend_dir    <= pend_dir_nxt;
`endif
      end
   end

   assign bus.motor_cw  = motor_cw_q;
   assign bus.motor_ccw = motor_ccw_q;
   assign bus.busy      = busy_q;
   assign bus.fault     = fault_q;

endmodule

// File: tb/tb_window_motor_ctrl.sv
// Bench for window_motor_ctrl: directed scenarios plus random traffic against a cycle-count model.
module tb_window_motor_ctrl;
   localparam int RUN_TIMEOUT = 20;
   localparam int DEAD_TIME   = 4;

   logic clk = 1'b0;
   logic n_reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   window_motor_ctrl_if bus ();

   window_motor_ctrl #(.RUN_TIMEOUT(RUN_TIMEOUT), .DEAD_TIME(DEAD_TIME), .CNT_W(8)) dut (
      .clk(clk), .n_reset(n_reset), .bus(bus)
   );

   always #5 clk = ~clk;

   // reference: direction of travel (+1 open, -1 close, 0 none), cycles driven so far,
   // dead cycles still owed, queued reversal and the fault latch
   int m_dir = 0, m_run = 0, m_dead = 0, m_pend = 0;
   bit m_fault = 0;
   bit lo_dl [2] = '{0, 0};
   bit lc_dl [2] = '{0, 0};

   task automatic model_edge();
      bit lo, lc, own, opp;
      lo = lo_dl[1];
      lc = lc_dl[1];
      lo_dl[1] = lo_dl[0]; lo_dl[0] = bus.limit_open;
      lc_dl[1] = lc_dl[0]; lc_dl[0] = bus.limit_closed;
      if (!n_reset) begin
         m_dir = 0; m_run = 0; m_dead = 0; m_pend = 0; m_fault = 0;
         lo_dl = '{0, 0}; lc_dl = '{0, 0};
      end else if (m_fault) begin
      end else if (lo && lc) begin
         m_fault = 1; m_dir = 0; m_dead = 0; m_pend = 0;
      end else if (m_dir != 0) begin
         own = (m_dir > 0) ? lo : lc;
         opp = (m_dir > 0) ? bus.close_ccw : bus.open_cw;
         if (own) begin
            m_dir = 0; m_dead = DEAD_TIME; m_pend = 0;
         end else if (m_run == RUN_TIMEOUT) begin
            m_fault = 1; m_dir = 0;
         end else if (opp) begin
`ifdef WINDOW_MOTOR_REVERSE_EN
            m_pend = -m_dir;
`else
            m_pend = 0;
`endif
            m_dir = 0; m_dead = DEAD_TIME;
         end else m_run++;
      end else if (m_dead > 0) begin
         if (m_dead == 1) begin
            m_dead = 0;
            if (m_pend != 0 && !((m_pend > 0) ? lo : lc)) begin
               m_dir = m_pend; m_run = 1;
            end
            m_pend = 0;
         end else m_dead--;
      end else if (bus.open_cw && !bus.close_ccw && !lo) begin
         m_dir = 1; m_run = 1;
      end else if (bus.close_ccw && !bus.open_cw && !lc) begin
         m_dir = -1; m_run = 1;
      end
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // one clock: advance the model on the edge, then compare every output 1 time unit later
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("motor_cw",  bus.motor_cw,  m_dir > 0);
      chk("motor_ccw", bus.motor_ccw, m_dir < 0);
      chk("busy",      bus.busy,      (m_dir != 0) || (m_dead > 0));
      chk("fault",     bus.fault,     m_fault);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse(input logic o, input logic c);
      bus.open_cw = o; bus.close_ccw = c;
      tick();
      bus.open_cw = 1'b0; bus.close_ccw = 1'b0;
   endtask

   task automatic do_reset();
      n_reset = 1'b0;
      ticks(2);
      n_reset = 1'b1;
   endtask

   initial begin
      int n;
      bus.open_cw = 1'b0; bus.close_ccw = 1'b0;
      bus.limit_open = 1'b0; bus.limit_closed = 1'b0;

      // reset state
      do_reset();
      chk("reset_busy", bus.busy, 1'b0);

      // 1: open run ended by limit_open
      pulse(1'b1, 1'b0);
      chk("s1_cw_on", bus.motor_cw, 1'b1);
      ticks(7);
      bus.limit_open = 1'b1;
      ticks(2);
      chk("s1_cw_still", bus.motor_cw, 1'b1);
      tick();
      chk("s1_cw_off", bus.motor_cw, 1'b0);
      ticks(3);
      chk("s1_busy_dead", bus.busy, 1'b1);
      tick();
      chk("s1_busy_off", bus.busy, 1'b0);
      chk("s1_fault", bus.fault, 1'b0);

      // 3: request toward active limit, then simultaneous requests
      pulse(1'b1, 1'b0);
      chk("s3_limit_ign", bus.busy, 1'b0);
      bus.limit_open = 1'b0;
      ticks(3);
      pulse(1'b1, 1'b1);
      chk("s3_both_ign", bus.busy, 1'b0);
      ticks(2);

      // 2: close run with no limit times out after exactly RUN_TIMEOUT cycles
      pulse(1'b0, 1'b1);
      n = int'(bus.motor_ccw);
      for (int i = 0; i < 25; i++) begin
         tick();
         n += int'(bus.motor_ccw);
      end
      chk_int("s2_ccw_cycles", n, RUN_TIMEOUT);
      chk("s2_fault", bus.fault, 1'b1);
      pulse(1'b1, 1'b0);
      ticks(3);
      pulse(1'b0, 1'b1);
      chk("s2_sticky", bus.fault, 1'b1);
      do_reset();
      chk("s2_cleared", bus.fault, 1'b0);

      // 4: opposite request at cycle 5 of an open run
      pulse(1'b1, 1'b0);
      ticks(4);
      pulse(1'b0, 1'b1);
      chk("s4_cw_off", bus.motor_cw, 1'b0);
      ticks(3);
      chk("s4_dead", bus.busy, 1'b1);
      tick();
`ifdef WINDOW_MOTOR_REVERSE_EN
      chk("s4_reverse", bus.motor_ccw, 1'b1);
`else
      chk("s4_idle", bus.busy, 1'b0);
`endif
      ticks(6);
      do_reset();

      // 5: both limits during a close run
      pulse(1'b0, 1'b1);
      ticks(3);
      bus.limit_open = 1'b1; bus.limit_closed = 1'b1;
      ticks(3);
      chk("s5_fault", bus.fault, 1'b1);
      chk("s5_drive", bus.motor_ccw, 1'b0);
      bus.limit_open = 1'b0; bus.limit_closed = 1'b0;
      do_reset();
      ticks(2);

      // 6: reset mid-run, then a fresh full-length timeout
      pulse(1'b1, 1'b0);
      ticks(5);
      n_reset = 1'b0;
      tick();
      chk("s6_rst_cw", bus.motor_cw, 1'b0);
      n_reset = 1'b1;
      pulse(1'b1, 1'b0);
      n = int'(bus.motor_cw);
      for (int i = 0; i < 25; i++) begin
         tick();
         n += int'(bus.motor_cw);
      end
      chk_int("s6_cw_cycles", n, RUN_TIMEOUT);
      do_reset();

      // random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         bus.open_cw   = ($urandom_range(0, 7) == 0);
         bus.close_ccw = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 23) == 0) bus.limit_open   = ~bus.limit_open;
         if ($urandom_range(0, 23) == 0) bus.limit_closed = ~bus.limit_closed;
         n_reset = ($urandom_range(0, 149) != 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
